product_accumulator: RTL and testbench
======================================

Name: product_accumulator

Overview:
- Downstream consumer of the multiplier's block-read stream.
- On command, raises EN_blockRead and captures NUM_WORDS words from memVal_data while VALID_memVal is high.
- Reduces the words to a running sum and a word count, then holds the result until the next stage acknowledges it.
- Sits between the multiplier and the result/reporting logic; frees the testbench or host from scoreboarding every product.

Parameters:
- DATA_W, 32, width of memVal_data words.
- NUM_WORDS, 64, words per block read; must match multiplier memory depth.
- SUM_W, 38, accumulator width, DATA_W + clog2(NUM_WORDS); no overflow possible at defaults.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- EN_accum  input  1  start request; accepted only when RDY_accum=1.
- RDY_accum  output  1  high in IDLE only.
- EN_blockRead  output  1  to multiplier; request to stream memory contents.
- VALID_memVal  input  1  from multiplier; memVal_data valid this cycle.
- memVal_data  input  DATA_W  from multiplier; product word.
- VALID_result  output  1  result_sum/result_count stable and valid.
- EN_getResult  input  1  consumer acknowledge; effective only when VALID_result=1.
- result_sum  output  SUM_W  sum of captured words, unsigned.
- result_count  output  7  number of words captured (NUM_WORDS on normal completion).

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE; all outputs 0 except RDY_accum=1; accumulator and counter cleared.
- States: IDLE, REQ, COLLECT, DONE.
- IDLE:
  - RDY_accum=1.
  - EN_accum=1 -> REQ; clear sum and count the same edge.
  - VALID_memVal in IDLE is ignored.
- REQ:
  - EN_blockRead=1, held until the first cycle VALID_memVal=1.
  - That cycle's word is accumulated (count=1). Go to COLLECT, and EN_blockRead drops the next cycle.
  - No timeout.
- COLLECT:
  - EN_blockRead=0.
  - Each cycle with VALID_memVal=1: sum += zero-extended memVal_data; count += 1.
  - Cycles with VALID_memVal=0 are gaps: hold sum and count, stay in COLLECT.
  - When the NUM_WORDS-th word is accumulated -> DONE on that edge.
  - VALID_memVal after count reaches NUM_WORDS is ignored.
- DONE:
  - VALID_result=1; result_sum and result_count registered and stable.
  - EN_getResult=1 -> IDLE next edge; VALID_result=0 and RDY_accum=1 the following cycle.
  - result_sum and result_count keep their last values in IDLE until the next start clears them.
- Latency: VALID_result rises 1 cycle after the edge capturing the last word. At full rate: start -> result = 1 (REQ) + stream wait + NUM_WORDS cycles.
- EN_accum outside IDLE is ignored (no queueing).
- EN_getResult outside DONE is ignored.
- Reset mid-operation (any state) returns to IDLE within one edge, with EN_blockRead=0 the next cycle; the partial sum is discarded.
- NUM_WORDS=1: REQ goes directly to DONE.

Optional Feature:
- Macro: PRODUCT_ACCUM_MAX_EN.
- Defined:
  - Adds output result_max (DATA_W): largest word captured.
  - Adds output result_max_idx (6 bits): index of the first occurrence of that maximum, counted from the first captured word = 0.
  - Ties keep the earlier index.
  - Both outputs are cleared on start and reset, and are valid with VALID_result.
- Undefined: ports absent; no compare logic.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then 1 -> RDY_accum=1, EN_blockRead=0, VALID_result=0, result_sum=0.
- Full-rate block: EN_accum pulse; words i*2 for i=0..63 streamed back-to-back after VALID_memVal rises -> result_sum=4032, result_count=64, VALID_result 1 cycle after the last word. EN_blockRead drops the cycle after the first VALID.
- Gapped stream: same words with VALID_memVal low every third cycle -> result_sum=4032, result_count=64; no gap cycle counted.
- Max values: all 64 words = 0xFFFFFFFF -> result_sum=0x3F_FFFF_FFC0, no wrap. With PRODUCT_ACCUM_MAX_EN: result_max=0xFFFFFFFF, result_max_idx=0.
- Handshake: EN_accum asserted during COLLECT and DONE ignored; EN_getResult in DONE -> RDY_accum=1 next cycle. A new run with words all 5 -> result_sum=320.
- Mid-run reset: rst_n=0 after 10 words -> IDLE, VALID_result=0. A following full run of words 1..64 -> result_sum=2080.

Source files
------------

// File: rtl/product_accumulator_if.sv
// Handshake and result bundle between the multiplier stream,
// the accumulator and the consumer; max outputs under PRODUCT_ACCUM_MAX_EN.
interface product_accumulator_if #(
   parameter int DATA_W = 32,
   parameter int SUM_W  = 38
);
   logic              EN_accum;
   logic              RDY_accum;
   logic              EN_blockRead;
   logic              VALID_memVal;
   logic [DATA_W-1:0] memVal_data;
   logic              VALID_result;
   logic              EN_getResult;
   logic [SUM_W-1:0]  result_sum;
   logic [6:0]        result_count;
`ifdef PRODUCT_ACCUM_MAX_EN
   logic [DATA_W-1:0] result_max;
   logic [5:0]        result_max_idx;
`endif

   modport slave (
`ifdef PRODUCT_ACCUM_MAX_EN
      output result_max,
      output result_max_idx,
`endif
      input  EN_accum,
      output RDY_accum,
      output EN_blockRead,
      input  VALID_memVal,
      input  memVal_data,
      output VALID_result,
      input  EN_getResult,
      output result_sum,
      output result_count
   );

   modport master (
`ifdef PRODUCT_ACCUM_MAX_EN
      input  result_max,
      input  result_max_idx,
`endif
      output EN_accum,
      input  RDY_accum,
      input  EN_blockRead,
      output VALID_memVal,
      output memVal_data,
      input  VALID_result,
      output EN_getResult,
      input  result_sum,
      input  result_count
   );
endinterface

// File: rtl/product_accumulator.sv
// Block-read reducer: sums NUM_WORDS streamed words and holds the result.
// Optional max/argmax tracking is enabled by PRODUCT_ACCUM_MAX_EN.
module product_accumulator #(
   parameter int DATA_W    = 32,
   parameter int NUM_WORDS = 64,
   parameter int SUM_W     = 38
) (
   input  logic clk,
   input  logic rst_n,
   product_accumulator_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      COLLECT,
      DONE
   } state_t;

   localparam logic [6:0] LAST = 7'(NUM_WORDS - 1);

   state_t           state;
   logic             rdy_q;
   logic             blk_q;
   logic             vres_q;
   logic [SUM_W-1:0] sum_q;
   logic [6:0]       cnt_q;
   logic [SUM_W-1:0] word_ext;

   assign word_ext = {{(SUM_W-DATA_W){1'b0}}, bus.memVal_data};

`ifdef PRODUCT_ACCUM_MAX_EN
   logic [DATA_W-1:0] max_q;
   logic [5:0]        idx_q;

   // strict compare so ties keep the earlier index
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         max_q <= '0;
         idx_q <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.EN_accum) begin
                  max_q <= '0;
                  idx_q <= '0;
               end
            end
            REQ: begin
               if (bus.VALID_memVal) begin
                  max_q <= bus.memVal_data;
                  idx_q <= '0;
               end
            end
            COLLECT: begin
               if (bus.VALID_memVal &&
                   bus.memVal_data > max_q) begin
                  max_q <= bus.memVal_data;
                  idx_q <= cnt_q[5:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.result_max     = max_q;
   assign bus.result_max_idx = idx_q;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         rdy_q  <= 1'b1;
         blk_q  <= 1'b0;
         vres_q <= 1'b0;
         sum_q  <= '0;
         cnt_q  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.EN_accum) begin
                  state <= REQ;
                  rdy_q <= 1'b0;
                  blk_q <= 1'b1;
                  sum_q <= '0;
                  cnt_q <= '0;
               end
            end
            REQ: begin
               if (bus.VALID_memVal) begin
                  sum_q <= word_ext;
                  cnt_q <= 7'd1;
                  blk_q <= 1'b0;
                  if (NUM_WORDS == 1) begin
                     state  <= DONE;
                     vres_q <= 1'b1;
                  end else begin
                     state <= COLLECT;
                  end
               end
            end
            COLLECT: begin
               if (bus.VALID_memVal) begin
                  sum_q <= sum_q + word_ext;
                  cnt_q <= cnt_q + 7'd1;
                  if (cnt_q == LAST) begin
                     state  <= DONE;
                     vres_q <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (bus.EN_getResult) begin
                  state  <= IDLE;
                  vres_q <= 1'b0;
                  rdy_q  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               rdy_q <= 1'b1;
               blk_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.RDY_accum    = rdy_q;
   assign bus.EN_blockRead = blk_q;
   assign bus.VALID_result = vres_q;
   assign bus.result_sum   = sum_q;
   assign bus.result_count = cnt_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboarded bench for product_accumulator; models the multiplier
// stream and checks sums, counts, handshakes and (optionally) the max.
module tb_product_accumulator;

   localparam int DATA_W    = 32;
   localparam int NUM_WORDS = 64;
   localparam int SUM_W     = 38;

   typedef logic [DATA_W-1:0] word_arr_t [NUM_WORDS];

   typedef struct {
      logic [SUM_W-1:0]  sum;
      logic [6:0]        count;
      logic [DATA_W-1:0] max;
      logic [5:0]        idx;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   product_accumulator_if #(.DATA_W(DATA_W), .SUM_W(SUM_W)) bus ();

   product_accumulator #(
      .DATA_W(DATA_W),
      .NUM_WORDS(NUM_WORDS),
      .SUM_W(SUM_W)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input word_arr_t w, input bit push);
      exp_t e;
      int   n;
      e.sum   = '0;
      e.count = 7'(NUM_WORDS);
      e.max   = '0;
      e.idx   = '0;
      for (int i = 0; i < NUM_WORDS; i++) begin
         e.sum = e.sum + SUM_W'(w[i]);
         if (i == 0 || w[i] > e.max) begin
            e.max = w[i];
            e.idx = 6'(i);
         end
      end
      n = 0;
      while (bus.RDY_accum !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      checks++;
      if (bus.RDY_accum !== 1'b1) begin
         errors++;
         $display("FAIL start_rdy: got %b want 1", bus.RDY_accum);
      end
      bus.EN_accum = 1'b1;
      tick();
      bus.EN_accum = 1'b0;
      checks++;
      if (bus.EN_blockRead !== 1'b1 || bus.RDY_accum !== 1'b0) begin
         errors++;
         $display("FAIL req_entry: blk=%b rdy=%b want 1/0",
                  bus.EN_blockRead, bus.RDY_accum);
      end
      if (push) sb.push_back(e);
   endtask

   task automatic stream_words(input word_arr_t w, input int nwords,
                               input int gap_period, input int wait_cycles);
      int i;
      int cyc;
      for (int k = 0; k < wait_cycles; k++) begin
         bus.VALID_memVal = 1'b0;
         tick();
         checks++;
         if (bus.EN_blockRead !== 1'b1) begin
            errors++;
            $display("FAIL blk_hold: got %b want 1", bus.EN_blockRead);
         end
      end
      i = 0;
      cyc = 0;
      while (i < nwords) begin
         if (gap_period > 0 && cyc % gap_period == gap_period - 1) begin
            bus.VALID_memVal = 1'b0;
            bus.memVal_data  = 32'hDEAD_BEEF;
         end else begin
            bus.VALID_memVal = 1'b1;
            bus.memVal_data  = w[i];
            i++;
         end
         cyc++;
         tick();
         if (i == 1 && bus.VALID_memVal) begin
            checks++;
            if (bus.EN_blockRead !== 1'b0) begin
               errors++;
               $display("FAIL blk_drop: got %b want 0", bus.EN_blockRead);
            end
         end
         if (i < NUM_WORDS) begin
            checks++;
            if (bus.VALID_result !== 1'b0) begin
               errors++;
               $display("FAIL early_valid: word %0d got %b want 0",
                        i, bus.VALID_result);
            end
         end
      end
      bus.VALID_memVal = 1'b0;
      bus.memVal_data  = '0;
   endtask

   task automatic finish_block(input string tag);
      exp_t e;
      checks++;
      if (bus.VALID_result !== 1'b1) begin
         errors++;
         $display("FAIL %s_latency: valid=%b want 1", tag, bus.VALID_result);
      end
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s_sb: got empty want entry", tag);
      end else begin
         e = sb.pop_front();
         if (bus.result_sum !== e.sum || bus.result_count !== e.count) begin
            errors++;
            $display("FAIL %s_result: sum=%0d cnt=%0d want %0d/%0d", tag,
                     bus.result_sum, bus.result_count, e.sum, e.count);
         end
`ifdef PRODUCT_ACCUM_MAX_EN
         checks++;
         if (bus.result_max !== e.max || bus.result_max_idx !== e.idx) begin
            errors++;
            $display("FAIL %s_max: max=%0h idx=%0d want %0h/%0d", tag,
                     bus.result_max, bus.result_max_idx, e.max, e.idx);
         end
`endif
      end
      bus.EN_getResult = 1'b1;
      tick();
      bus.EN_getResult = 1'b0;
      checks++;
      if (bus.RDY_accum !== 1'b1 || bus.VALID_result !== 1'b0) begin
         errors++;
         $display("FAIL %s_ack: rdy=%b valid=%b want 1/0", tag,
                  bus.RDY_accum, bus.VALID_result);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if (bus.RDY_accum !== 1'b1 || bus.EN_blockRead !== 1'b0 ||
          bus.VALID_result !== 1'b0 || bus.result_sum !== '0 ||
          bus.result_count !== '0) begin
         errors++;
         $display("FAIL reset: rdy=%b blk=%b vr=%b sum=%0h cnt=%0d want 1/0/0/0/0",
                  bus.RDY_accum, bus.EN_blockRead, bus.VALID_result,
                  bus.result_sum, bus.result_count);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (bus.RDY_accum !== 1'b1 || bus.VALID_result !== 1'b0) begin
         errors++;
         $display("FAIL post_reset: rdy=%b vr=%b want 1/0",
                  bus.RDY_accum, bus.VALID_result);
      end
   endtask

   task automatic test_full_rate();
      word_arr_t w;
      for (int i = 0; i < NUM_WORDS; i++) w[i] = DATA_W'(i * 2);
      start_run(w, 1'b1);
      stream_words(w, NUM_WORDS, 0, 2);
      finish_block("full");
   endtask

   task automatic test_gapped();
      word_arr_t w;
      for (int i = 0; i < NUM_WORDS; i++) w[i] = DATA_W'(i * 2);
      start_run(w, 1'b1);
      stream_words(w, NUM_WORDS, 3, 0);
      finish_block("gap");
   endtask

   task automatic test_max_values();
      word_arr_t w;
      for (int i = 0; i < NUM_WORDS; i++) w[i] = 32'hFFFF_FFFF;
      start_run(w, 1'b1);
      stream_words(w, NUM_WORDS, 0, 1);
      checks++;
      if (bus.result_sum !== 38'h3F_FFFF_FFC0) begin
         errors++;
         $display("FAIL max_nowrap: got %0h want 3fffffffc0", bus.result_sum);
      end
      finish_block("maxval");
   endtask

   task automatic test_handshake();
      word_arr_t w;
      logic [SUM_W-1:0] held;
      held = bus.result_sum;
      bus.VALID_memVal = 1'b1;
      bus.memVal_data  = 32'd7;
      bus.EN_getResult = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (bus.RDY_accum !== 1'b1 || bus.EN_blockRead !== 1'b0 ||
             bus.result_sum !== held) begin
            errors++;
            $display("FAIL idle_ignore: rdy=%b blk=%b sum=%0h want 1/0/%0h",
                     bus.RDY_accum, bus.EN_blockRead, bus.result_sum, held);
         end
      end
      bus.VALID_memVal = 1'b0;
      bus.EN_getResult = 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) w[i] = 32'd5;
      start_run(w, 1'b1);
      bus.EN_accum     = 1'b1;
      bus.EN_getResult = 1'b1;
      stream_words(w, NUM_WORDS, 0, 1);
      bus.EN_getResult = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (bus.VALID_result !== 1'b1 || bus.RDY_accum !== 1'b0 ||
             bus.result_sum !== 38'd320) begin
            errors++;
            $display("FAIL done_hold: vr=%b rdy=%b sum=%0d want 1/0/320",
                     bus.VALID_result, bus.RDY_accum, bus.result_sum);
         end
      end
      bus.EN_accum = 1'b0;
      finish_block("hs");
   endtask

   task automatic test_mid_reset();
      word_arr_t w;
      for (int i = 0; i < NUM_WORDS; i++) w[i] = DATA_W'(i + 1);
      start_run(w, 1'b0);
      stream_words(w, 10, 0, 1);
      rst_n = 1'b0;
      tick();
      checks++;
      if (bus.RDY_accum !== 1'b1 || bus.VALID_result !== 1'b0 ||
          bus.EN_blockRead !== 1'b0 || bus.result_sum !== '0) begin
         errors++;
         $display("FAIL mid_reset: rdy=%b vr=%b blk=%b sum=%0d want 1/0/0/0",
                  bus.RDY_accum, bus.VALID_result, bus.EN_blockRead,
                  bus.result_sum);
      end
      rst_n = 1'b1;
      tick();
      start_run(w, 1'b1);
      stream_words(w, NUM_WORDS, 0, 1);
      checks++;
      if (bus.result_sum !== 38'd2080) begin
         errors++;
         $display("FAIL rerun_sum: got %0d want 2080", bus.result_sum);
      end
      finish_block("rerun");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.EN_accum     = 1'b0;
      bus.VALID_memVal = 1'b0;
      bus.memVal_data  = '0;
      bus.EN_getResult = 1'b0;
      test_reset();
      test_full_rate();
      test_gapped();
      test_max_values();
      test_handshake();
      test_mid_reset();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: got %0d want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
